// File: rtl/aes_pkg.sv
// Shared AES substitution tables.
//   SBOX / INV_SBOX : FIPS-197 forward and inverse S-box, indexed by input byte.
//   sbox_lookup(b, inv) : returns SBOX[b] when inv = 0, INV_SBOX[b] when inv = 1.
package aes_pkg;

  localparam int unsigned SBOX_DEPTH = 256;

  localparam logic [7:0] SBOX [SBOX_DEPTH] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [SBOX_DEPTH] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_dual.sv
// Single-byte forward/inverse S-box, purely combinational table lookup.
//   din  : input byte
//   inv  : 0 = forward S-box, 1 = inverse S-box
//   dout : substituted byte
module sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  always_comb begin
    dout = sbox_lookup(din, inv);
  end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine with valid/ready at both ends.
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_inv selects inverse S-box per transaction
//   in_data, in_tag     : NUM_BYTES state bytes (lane i = in_data[8*i +: 8]) and sideband tag
//   out_valid/out_ready : output handshake; out_data/out_tag hold while stalled
//   busy                : any pipeline stage holds a valid transaction
// PIPE_STAGES = 1 looks up on the input and registers the result (latency 1);
// PIPE_STAGES = 2 registers the raw input first, then looks up into the output register (latency 2).
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = 16,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);

  localparam int unsigned DW = 8 * NUM_BYTES;

  if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
    $error("sub_bytes_pipe: NUM_BYTES must be in 1..16");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 2) begin : g_bad_pipe_stages
    $error("sub_bytes_pipe: PIPE_STAGES must be 1 or 2");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("sub_bytes_pipe: TAG_W must be at least 1");
  end

  // Lookup source and the transaction feeding the output stage; which
  // signals these are depends on the pipeline depth.
  logic [DW-1:0]    lk_in;
  logic             lk_inv;
  logic [DW-1:0]    lk_out;
  logic             up_valid;
  logic [TAG_W-1:0] up_tag;

  // Output stage registers.
  logic             v_o;
  logic [DW-1:0]    d_o;
  logic [TAG_W-1:0] t_o;
  logic             adv_last;

  assign adv_last = !v_o || out_ready;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    sbox_dual u_sbox (
      .din  (lk_in[8*i +: 8]),
      .inv  (lk_inv),
      .dout (lk_out[8*i +: 8])
    );
  end

  if (PIPE_STAGES == 2) begin : g_two
    logic             v_1;
    logic             inv_1;
    logic [DW-1:0]    d_1;
    logic [TAG_W-1:0] t_1;
    logic             adv_1;

    assign adv_1 = !v_1 || adv_last;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_1   <= 1'b0;
        inv_1 <= 1'b0;
        d_1   <= '0;
        t_1   <= '0;
      end else if (adv_1) begin
        v_1 <= in_valid;
        if (in_valid) begin
          inv_1 <= in_inv;
          d_1   <= in_data;
          t_1   <= in_tag;
        end
      end
    end

    assign in_ready = adv_1;
    assign lk_in    = d_1;
    assign lk_inv   = inv_1;
    assign up_valid = v_1;
    assign up_tag   = t_1;
    assign busy     = v_1 | v_o;
  end else begin : g_one
    assign in_ready = adv_last;
    assign lk_in    = in_data;
    assign lk_inv   = in_inv;
    assign up_valid = in_valid;
    assign up_tag   = in_tag;
    assign busy     = v_o;
  end

  // Data registers load only on a valid upstream transaction; bubbles
  // clear the valid bit but leave the last result in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_o <= 1'b0;
      d_o <= '0;
      t_o <= '0;
    end else if (adv_last) begin
      v_o <= up_valid;
      if (up_valid) begin
        d_o <= lk_out;
        t_o <= up_tag;
      end
    end
  end

  assign out_valid = v_o;
  assign out_data  = d_o;
  assign out_tag   = t_o;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Self-checking bench: four engines (16/2, 4/2, 1/1, 16/1 lanes/stages) share
// stimulus; a per-engine scoreboard checks every result against S-box tables
// built here from GF(2^8) inversion plus the affine transform.
module tb_sub_bytes_pipe;

  localparam int NB [4] = '{16, 4, 1, 16};
  localparam int PS [4] = '{2, 2, 1, 1};

  logic         clk = 1'b0;
  logic         reset_n, in_valid, in_inv, out_ready;
  logic [127:0] in_data;
  logic [4:0]   in_tag;

  logic         ir [4];
  logic         ov [4];
  logic         bz [4];
  logic [127:0] od [4];
  logic [4:0]   ot [4];
  logic [31:0]  od1;
  logic [7:0]   od2;

  assign od[1] = {96'h0, od1};
  assign od[2] = {120'h0, od2};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit lat_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_pipe #(.NUM_BYTES(16), .PIPE_STAGES(2), .TAG_W(5)) u_d0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]), .in_inv(in_inv),
    .in_data(in_data), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_tag(ot[0]), .busy(bz[0]));
  sub_bytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(2), .TAG_W(5)) u_d1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]), .in_inv(in_inv),
    .in_data(in_data[31:0]), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od1), .out_tag(ot[1]), .busy(bz[1]));
  sub_bytes_pipe #(.NUM_BYTES(1), .PIPE_STAGES(1), .TAG_W(5)) u_d2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]), .in_inv(in_inv),
    .in_data(in_data[7:0]), .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od2), .out_tag(ot[2]), .busy(bz[2]));
  sub_bytes_pipe #(.NUM_BYTES(16), .PIPE_STAGES(1), .TAG_W(5)) u_d3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[3]), .in_inv(in_inv),
    .in_data(in_data), .in_tag(in_tag), .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(od[3]), .out_tag(ot[3]), .busy(bz[3]));

  // ---------------- reference model ----------------
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    if (x == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] w;
    w = {b, b} << k;
    return w[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] b, s;
    for (int x = 0; x < 256; x++) begin
      b = ginv(8'(x));
      s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int n);
    logic [127:0] r = '0;
    for (int j = 0; j < n; j++)
      r[8*j +: 8] = inv ? inv_t[d[8*j +: 8]] : fwd_t[d[8*j +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] d;
    logic [4:0]   t;
    int           c;
  } exp_t;
  exp_t q [4][$];

  always @(negedge reset_n) begin
    for (int k = 0; k < 4; k++) q[k].delete();
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && out_ready) begin
          chk($sformatf("sb%0d_pending", k), 128'(q[k].size() > 0), 128'(1));
          if (q[k].size() > 0) begin
            e = q[k].pop_front();
            chk($sformatf("sb%0d_data", k), od[k], e.d);
            chk($sformatf("sb%0d_tag", k), 128'(ot[k]), 128'(e.t));
            if (lat_on) chk($sformatf("sb%0d_latency", k), 128'(cyc - e.c), 128'(PS[k]));
          end
        end
        if (in_valid && ir[k]) begin
          e.d = model(in_data, in_inv, NB[k]);
          e.t = in_tag;
          e.c = cyc;
          q[k].push_back(e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(input int k);
    int n = 0;
    @(negedge clk);
    while (!ov[k] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_ov%0d", k), 128'(ov[k]), 128'(1));
  endtask

  initial begin
    logic [127:0] x, y, sd;
    logic [4:0]   st;
    logic         prev_ov, prev_or, acc;
    int           n;

    build_tables();
    reset_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_out_valid", 128'(ov[k]), 128'(0));
      chk("rst_busy", 128'(bz[k]), 128'(0));
      chk("rst_out_data", od[k], '0);
      chk("rst_out_tag", 128'(ot[k]), '0);
    end
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) chk("rst_in_ready", 128'(ir[k]), 128'(1));
    tick();

    // Forward vector on the 4-lane, 2-stage engine.
    in_valid = 1'b1; in_data = {96'h0, 32'h33221100}; in_inv = 1'b0; in_tag = 5'h05;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fwd_ov_c1", 128'(ov[1]), 128'(0));
    chk("fwd_busy_c1", 128'(bz[1]), 128'(1));
    @(negedge clk);
    chk("fwd_ov_c2", 128'(ov[1]), 128'(1));
    chk("fwd_data", od[1], {96'h0, 32'hC3938263});
    chk("fwd_tag", 128'(ot[1]), 128'(5'h05));
    chk("fwd_busy_c2", 128'(bz[1]), 128'(1));
    @(negedge clk);
    chk("fwd_busy_c3", 128'(bz[1]), 128'(0));
    tick();

    // Inverse vector.
    in_valid = 1'b1; in_data = {96'h0, 32'h7C16ED63}; in_inv = 1'b1; in_tag = 5'h0A;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("inv_ov", 128'(ov[1]), 128'(1));
    chk("inv_data", od[1], {96'h0, 32'h01FF5300});
    tick();

    // Round trip on the 16-lane engine.
    for (int r = 0; r < 3; r++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; in_data = x; in_inv = 1'b0; in_tag = 5'(r);
      tick();
      in_valid = 1'b0;
      wait_ov(0);
      y = od[0];
      tick();
      in_valid = 1'b1; in_data = y; in_inv = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_ov(0);
      chk("round_trip", od[0], x);
      tick();
    end
    repeat (3) tick();

    // Back-to-back stream, alternating mode, no bubbles.
    lat_on = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        in_valid = 1'b1; in_inv = i[0]; in_tag = 5'(i);
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 20) chk("stream_in_ready", 128'(ir[0]), 128'(1));
      if (i >= 2) begin
        chk("stream_out_valid", 128'(ov[0]), 128'(1));
        chk("stream_tag", 128'(ot[0]), 128'(i - 2));
      end
      tick();
    end
    repeat (3) tick();
    lat_on = 1'b0;

    // Backpressure on the 2-stage engine.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b0; in_tag = 5'd20; in_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("bp_ready_a", 128'(ir[0]), 128'(1));
    tick();
    in_tag = 5'd21; in_inv = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("bp_ready_b", 128'(ir[0]), 128'(1));
    tick();
    in_tag = 5'd22; in_inv = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("bp_full_ready", 128'(ir[0]), 128'(0));
    chk("bp_full_valid", 128'(ov[0]), 128'(1));
    chk("bp_full_tag", 128'(ot[0]), 128'(20));
    sd = od[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_ready", 128'(ir[0]), 128'(0));
      chk("bp_hold_valid", 128'(ov[0]), 128'(1));
      chk("bp_hold_tag", 128'(ot[0]), 128'(20));
      chk("bp_hold_data", od[0], sd);
    end
    tick();
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(ir[0]), 128'(1));
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", 128'(ov[0]), 128'(1));
    chk("bp_after_tag", 128'(ot[0]), 128'(21));
    chk("bp_after_ready", 128'(ir[0]), 128'(0));
    tick();
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (bz[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_drain_busy", 128'(bz[0]), 128'(0));
    tick();

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd3; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_tag = 5'd4; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_valid", 128'(ov[k]), 128'(0));
      chk("mid_rst_busy", 128'(bz[k]), 128'(0));
      chk("mid_rst_data", od[k], '0);
      chk("mid_rst_tag", 128'(ot[k]), '0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    x = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_data = x; in_inv = 1'b1; in_tag = 5'd9;
    tick();
    in_valid = 1'b0;
    wait_ov(0);
    chk("post_rst_data", od[0], model(x, 1'b1, 16));
    chk("post_rst_tag", 128'(ot[0]), 128'(9));
    @(negedge clk);
    chk("post_rst_no_stale", 128'(ov[0]), 128'(0));
    chk("post_rst_idle", 128'(bz[0]), 128'(0));
    tick();

    // All byte values in both modes, every lane, latency checked.
    lat_on = 1'b1;
    for (int v = 0; v < 256; v++) begin
      for (int m = 0; m < 2; m++) begin
        in_valid = 1'b1; in_inv = m[0]; in_tag = 5'(v);
        for (int j = 0; j < 16; j++) in_data[8*j +: 8] = 8'(v + 17 * j);
        tick();
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    lat_on = 1'b0;

    // Random traffic with random backpressure; output stability on stalls.
    prev_ov = 1'b0; prev_or = 1'b1; sd = '0; st = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prev_ov && !prev_or) begin
        chk("rand_hold_valid", 128'(ov[0]), 128'(1));
        chk("rand_hold_data", od[0], sd);
        chk("rand_hold_tag", 128'(ot[0]), 128'(st));
      end
      acc = in_valid && ir[0];
      prev_ov = ov[0]; prev_or = out_ready; sd = od[0]; st = ot[0];
      tick();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(2) != 0);
        in_inv = $urandom_range(1) == 1;
        in_tag = 5'($urandom);
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = ($urandom_range(3) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) chk("sb_empty", 128'(q[k].size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
